jambu_fsr_unit: RTL and testbench

Parametrised, pipelined funnel-shift unit for the JAMBU RISC-V ISE, generalising the single-cycle 32-bit `fsri` datapath. Concatenates two XLEN-bit source registers, rotates the 2·XLEN-bit value right or left by an immediate or register amount, and returns the low XLEN bits. Sits behind the core's ISE dispatch port, uses valid/ready handshakes on both sides, and runs as a two-stage pipeline with backpressure and flush.

---
 rtl/jambu_ise_pkg.sv | 25 ++
 rtl/jambu_rotr_stage.sv | 23 ++
 rtl/jambu_fsr_unit.sv | 120 ++++++++++++
 tb/tb_jambu_fsr_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jambu_ise_pkg.sv
// Shared definitions for the JAMBU ISE funnel-shift datapath: op-select codes,
// shift-amount width and left-to-right amount conversion.
package jambu_ise_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned AMT_MAX_W = 7;

    // Op-select vector is {op_fsl, op_fsr, op_fsri}
    localparam logic [OP_W-1:0] OP_FSRI = 3'b001;
    localparam logic [OP_W-1:0] OP_FSR  = 3'b010;
    localparam logic [OP_W-1:0] OP_FSL  = 3'b100;

    function automatic int unsigned sw_of(input int unsigned xlen);
        return $clog2(2 * xlen);
    endfunction

    // Left by a == right by (2*XLEN - a) mod 2*XLEN, i.e. two's complement within sw bits
    function automatic logic [AMT_MAX_W-1:0] left_to_right(input logic [AMT_MAX_W-1:0] amt,
                                                          input int unsigned         sw);
        logic [AMT_MAX_W-1:0] mask;
        mask = AMT_MAX_W'((32'd1 << sw) - 32'd1);
        return (AMT_MAX_W'(0) - amt) & mask;
    endfunction

endpackage

// File: rtl/jambu_rotr_stage.sv
// Combinational right rotator over W bits; amt[i] rotates by 2**(LSB+i) bit positions.
module jambu_rotr_stage #(
    parameter int unsigned W     = 64,
    parameter int unsigned AMT_W = 3,
    parameter int unsigned LSB   = 0
) (
    input  logic [W-1:0]     din,
    input  logic [AMT_W-1:0] amt,
    output logic [W-1:0]     dout
);

    logic [W-1:0] lvl [0:AMT_W];

    assign lvl[0] = din;

    for (genvar i = 0; i < AMT_W; i++) begin : g_lvl
        localparam int unsigned SH = (32'd1 << (LSB + i)) % W;
        assign lvl[i+1] = amt[i] ? ((lvl[i] >> SH) | (lvl[i] << (W - SH))) : lvl[i];
    end

    assign dout = lvl[AMT_W];

endmodule

// File: rtl/jambu_fsr_unit.sv
// Two-stage pipelined funnel-shift unit: rd = rotr({rs2, rs1}, amt)[XLEN-1:0],
// with valid/ready handshakes, backpressure and flush.
module jambu_fsr_unit
    import jambu_ise_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SW   = sw_of(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_fsri,
    input  logic            op_fsr,
    input  logic            op_fsl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rs3,
    input  logic [SW-1:0]   imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    localparam int unsigned OW = 2 * XLEN;
    localparam int unsigned HW = SW - 3;

    logic [OP_W-1:0] op_sel;
    logic            op_ok;
    logic [SW-1:0]   amt;
    logic [OW-1:0]   rot_lo;
    logic [OW-1:0]   rot_hi;

    logic            s1_valid;
    logic [OW-1:0]   s1_data;
    logic [HW-1:0]   s1_hi;
    logic            s1_zero;
    logic            s2_valid;

    logic            s1_move;
    logic            s1_load;

    // Upper rs3 bits and upper rotated half are architecturally ignored
    logic            unused_bits;
    assign unused_bits = ^{rs3[XLEN-1:SW], rot_hi[OW-1:XLEN]};

    assign op_sel = {op_fsl, op_fsr, op_fsri};
    assign op_ok  = (op_sel == OP_FSRI) || (op_sel == OP_FSR) || (op_sel == OP_FSL);

    always_comb begin
        amt = '0;
        case (op_sel)
            OP_FSRI: amt = imm;
            OP_FSR:  amt = rs3[SW-1:0];
            OP_FSL:  amt = SW'(left_to_right(AMT_MAX_W'(rs3[SW-1:0]), SW));
            default: amt = '0;
        endcase
    end

    assign s1_move   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s1_move;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    jambu_rotr_stage #(
        .W     (OW),
        .AMT_W (3),
        .LSB   (0)
    ) u_rot_lo (
        .din  ({rs2, rs1}),
        .amt  (amt[2:0]),
        .dout (rot_lo)
    );

    jambu_rotr_stage #(
        .W     (OW),
        .AMT_W (HW),
        .LSB   (3)
    ) u_rot_hi (
        .din  (s1_data),
        .amt  (s1_hi),
        .dout (rot_hi)
    );

    // S1: fine rotation (amt[2:0]) plus remaining byte-granular amount
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_hi    <= '0;
            s1_zero  <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_data  <= rot_lo;
            s1_hi    <= amt[SW-1:3];
            s1_zero  <= !op_ok;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: coarse rotation, zero mask, result register held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            rd       <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_move) begin
            s2_valid <= 1'b1;
            rd       <= s1_zero ? '0 : rot_hi[XLEN-1:0];
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jambu_fsr_unit.sv
// Drives XLEN=32 and XLEN=64 instances in lockstep against a queue-based
// rotation model; directed test-plan cases followed by random traffic.
module tb_jambu_fsr_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        op_fsri;
    logic        op_fsr;
    logic        op_fsl;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic [6:0]  imm;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] rd32;
    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] rd64;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_now = 0;
    int n_done  = 0;

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        int          cyc;
    } exp_t;

    exp_t q[$];

    jambu_fsr_unit #(.XLEN(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .op_fsri   (op_fsri),
        .op_fsr    (op_fsr),
        .op_fsl    (op_fsl),
        .rs1       (rs1[31:0]),
        .rs2       (rs2[31:0]),
        .rs3       (rs3[31:0]),
        .imm       (imm[5:0]),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .rd        (rd32)
    );

    jambu_fsr_unit #(.XLEN(64)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .op_fsri   (op_fsri),
        .op_fsr    (op_fsr),
        .op_fsl    (op_fsl),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs3       (rs3),
        .imm       (imm),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .rd        (rd64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc_now);
        end
    endtask

    // Reference: rotate the 2x-bit concatenation right, keep low x bits
    function automatic logic [63:0] ref_rd(input int x, input logic [2:0] ops,
                                           input logic [63:0] a1, input logic [63:0] a2,
                                           input logic [63:0] a3, input logic [6:0] im);
        logic [127:0] opr;
        logic [127:0] rot;
        int n;
        int amt;
        n = 2 * x;
        if ($countones(ops) != 1) return 64'd0;
        if (x == 32) opr = {64'd0, a2[31:0], a1[31:0]};
        else         opr = {a2, a1};
        if (ops[0]) amt = int'(im) % n;
        else        amt = int'(a3[6:0]) % n;
        if (ops[2]) amt = (n - amt) % n;
        rot = (opr >> amt) | (opr << (n - amt));
        if (x == 32) return {32'd0, rot[31:0]};
        return rot[63:0];
    endfunction

    // One clock: check outputs against the model, then advance model across the edge
    task automatic step();
        bit   exp_rdy;
        bit   exp_ov;
        bit   acc;
        bit   drn;
        exp_t e;
        #1;
        exp_ov  = (q.size() > 0) && (q[0].cyc < cyc_now);
        exp_rdy = !((q.size() >= 2) && !out_ready);
        check("in_ready32", 64'(in_ready32), 64'(exp_rdy));
        check("in_ready64", 64'(in_ready64), 64'(exp_rdy));
        check("out_valid32", 64'(out_valid32), 64'(exp_ov));
        check("out_valid64", 64'(out_valid64), 64'(exp_ov));
        if (exp_ov) begin
            check("rd32", 64'(rd32), q[0].e32);
            check("rd64", rd64, q[0].e64);
        end
        if (out_valid32 && out_ready) n_done++;
        acc   = in_valid && exp_rdy && !flush && !rst;
        drn   = exp_ov && out_ready;
        e.e32 = ref_rd(32, {op_fsl, op_fsr, op_fsri}, rs1, rs2, rs3, imm);
        e.e64 = ref_rd(64, {op_fsl, op_fsr, op_fsri}, rs1, rs2, rs3, imm);
        @(posedge clk);
        cyc_now++;
        e.cyc = cyc_now;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_req(input bit v, input logic [2:0] ops, input logic [63:0] r3,
                           input logic [6:0] im);
        in_valid                  = v;
        {op_fsl, op_fsr, op_fsri} = ops;
        rs3                       = r3;
        imm                       = im;
    endtask

    // Single isolated request; result must be valid after the second edge
    task automatic directed(input string tag, input logic [2:0] ops, input logic [63:0] r3,
                            input logic [6:0] im, input logic [63:0] w32, input logic [63:0] w64);
        out_ready = 1'b1;
        set_req(1'b1, ops, r3, im);
        step();
        in_valid = 1'b0;
        step();
        check({tag, "_ov"}, 64'(out_valid32 & out_valid64), 64'd1);
        check({tag, "_32"}, 64'(rd32), w32);
        check({tag, "_64"}, rd64, w64);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        rs1       = 64'h76543210_89ABCDEF;
        rs2       = 64'hFEDCBA98_01234567;
        set_req(1'b0, 3'b000, 64'd0, 7'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_rd32", 64'(rd32), 64'd0);
        check("reset_rd64", rd64, 64'd0);
        step();

        directed("fsri8",   3'b001, 64'd0, 7'd8,   64'h6789ABCD, 64'h67765432_1089ABCD);
        directed("fsr0",    3'b010, 64'd0, 7'd0,   64'h89ABCDEF, 64'h76543210_89ABCDEF);
        directed("fsr32",   3'b010, 64'd32, 7'd0,  64'h01234567, 64'h01234567_76543210);
        directed("fsr36",   3'b010, 64'd36, 7'd0,  64'hF0123456, 64'h80123456_77654321);
        directed("fsr36hi", 3'b010, 64'hFFFFFFFF_FFFFFF24, 7'd0, 64'hF0123456, 64'h80123456_77654321);
        directed("fsl8",    3'b100, 64'd8, 7'd0,   64'hABCDEF01, 64'h54321089_ABCDEFFE);
        directed("fsl0",    3'b100, 64'd0, 7'd0,   64'h89ABCDEF, 64'h76543210_89ABCDEF);
        directed("fsr64",   3'b010, 64'd64, 7'd0,  64'h89ABCDEF, 64'hFEDCBA98_01234567);
        directed("fsr127",  3'b010, 64'd127, 7'd0, 64'h13579BDE, 64'hECA86421_13579BDF);
        directed("fsri127", 3'b001, 64'd0, 7'd127, 64'h13579BDE, 64'hECA86421_13579BDF);
        directed("multi",   3'b011, 64'd36, 7'd8,  64'd0,        64'd0);

        // Backpressure: three back-to-back requests, consumer stalled three cycles
        n_done    = 0;
        out_ready = 1'b0;
        set_req(1'b1, 3'b001, 64'd0, 7'd4);
        step();
        set_req(1'b1, 3'b010, 64'd20, 7'd0);
        step();
        set_req(1'b1, 3'b100, 64'd12, 7'd0);
        step();
        check("full_in_ready", 64'(in_ready32 | in_ready64), 64'd0);
        step();
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("bp_completed", 64'(n_done), 64'd3);

        // Flush with both stages full; a same-cycle request is dropped
        out_ready = 1'b0;
        set_req(1'b1, 3'b001, 64'd0, 7'd16);
        step();
        step();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_ov", 64'(out_valid32 | out_valid64), 64'd0);
        out_ready = 1'b1;
        n_done    = 0;
        repeat (3) step();
        check("flush_no_stale", 64'(n_done), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        set_req(1'b1, 3'b010, 64'd40, 7'd0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_ov", 64'(out_valid32 | out_valid64), 64'd0);
        check("rst_rd32", 64'(rd32), 64'd0);
        check("rst_rd64", rd64, 64'd0);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r        = int'($urandom_range(0, 9));
            in_valid = ($urandom_range(0, 9) < 7);
            if (r == 0) {op_fsl, op_fsr, op_fsri} = 3'($urandom);
            else        {op_fsl, op_fsr, op_fsri} = 3'b001 << $urandom_range(0, 2);
            rs1       = {$urandom, $urandom};
            rs2       = {$urandom, $urandom};
            rs3       = {$urandom, $urandom};
            imm       = 7'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
